// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor
//   Measures the period of an asynchronous monitored clock (clk_in) in
//   system-clock cycles, reports each period, asserts lock after LOCK_CNT
//   consecutive in-tolerance periods and flags loss of clk_in.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous reset, active-high
//   en          in   monitor enable (sync to clk)
//   clk_in      in   monitored clock (async to clk)
//   period      out  last measured period, clk cycles (saturating)
//   period_vld  out  one-cycle pulse when period updates
//   in_range    out  last period within NOM_PERIOD +/- TOL
//   lock        out  LOCK_CNT consecutive in-range periods seen
//   timeout     out  clk_in lost (high while in LOST)
//
// Optional (macro CLK_MON_MINMAX_EN):
//   minmax_clr  in   clear min/max trackers (priority over update)
//   period_min  out  smallest period seen since reset/clear
//   period_max  out  largest period seen since reset/clear
module clk_freq_monitor #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned NOM_PERIOD = 100,
    parameter int unsigned TOL        = 2,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clk_in,
`ifdef CLK_MON_MINMAX_EN
    input  logic             minmax_clr,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max,
`endif
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             in_range,
    output logic             lock,
    output logic             timeout
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0]         LOCK_V    = GW'(LOCK_CNT);
    localparam logic [CNT_W:0]        TIMEOUT_V = (CNT_W+1)'(TIMEOUT);
    localparam logic signed [CNT_W:0] NOM_S     = (CNT_W+1)'(NOM_PERIOD);
    localparam logic signed [CNT_W:0] TOL_S     = (CNT_W+1)'(TOL);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        MEASURE,
        LOST
    } state_t;

    state_t            state;
    logic              sync1, sync2, prev;
    logic [CNT_W-1:0]  cnt;
    logic [GW-1:0]     good_cnt;

    logic              rise;
    logic [CNT_W:0]    cnt_inc;
    logic [CNT_W-1:0]  period_sat;
    logic signed [CNT_W:0] diff;
    logic              in_rng;
    logic              hit_timeout;
    logic [GW-1:0]     good_inc;

    always_comb begin
        rise        = sync2 & ~prev;
        cnt_inc     = {1'b0, cnt} + 1'b1;
        // cnt+1 doubles as the saturating counter increment and the period
        period_sat  = cnt_inc[CNT_W] ? '1 : cnt_inc[CNT_W-1:0];
        // one extra sign bit keeps the deviation from wrapping
        diff        = $signed({1'b0, period_sat}) - NOM_S;
        in_rng      = (diff <= TOL_S) && (diff >= -TOL_S);
        hit_timeout = (cnt_inc == TIMEOUT_V);
        good_inc    = (good_cnt == LOCK_V) ? good_cnt : good_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= IDLE;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            prev       <= 1'b0;
            cnt        <= '0;
            good_cnt   <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            in_range   <= 1'b0;
            lock       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            sync1      <= clk_in;
            sync2      <= sync1;
            prev       <= sync2;
            period_vld <= 1'b0;
            if (!en) begin
                state    <= IDLE;
                cnt      <= '0;
                good_cnt <= '0;
                lock     <= 1'b0;
                timeout  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        state <= WAIT_FIRST;
                    end
                    WAIT_FIRST, MEASURE: begin
                        if (rise) begin
                            // first edge after IDLE is only a reference
                            cnt   <= '0;
                            state <= MEASURE;
                            if (state == MEASURE) begin
                                period     <= period_sat;
                                period_vld <= 1'b1;
                                in_range   <= in_rng;
                                if (in_rng) begin
                                    good_cnt <= good_inc;
                                    lock     <= (good_inc == LOCK_V);
                                end else begin
                                    good_cnt <= '0;
                                    lock     <= 1'b0;
                                end
                            end
                        end else begin
                            cnt <= period_sat;
                            if (hit_timeout) begin
                                state    <= LOST;
                                timeout  <= 1'b1;
                                lock     <= 1'b0;
                                good_cnt <= '0;
                            end
                        end
                    end
                    LOST: begin
                        if (rise) begin
                            cnt     <= '0;
                            timeout <= 1'b0;
                            state   <= MEASURE;
                        end else begin
                            cnt <= period_sat;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef CLK_MON_MINMAX_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            period_min <= '1;
            period_max <= '0;
        end else if (minmax_clr) begin
            period_min <= '1;
            period_max <= '0;
        end else if (en && state == MEASURE && rise) begin
            if (period_sat < period_min) period_min <= period_sat;
            if (period_sat > period_max) period_max <= period_sat;
        end
    end
`endif

endmodule

// File: doc/clk_freq_monitor.md
Name: clk_freq_monitor

Overview:
- Receive-side checker for the divided slow clock: measures the period of an incoming clock (nominally the 1 MHz divider output) in system-clock cycles.
- Reports each measured period, asserts lock after consecutive in-tolerance periods, and flags loss of clock.
- Sits beside the clock divider, on the same 100 MHz clk domain, as its health monitor.

Parameters:
- CNT_W, 16, width of period counter and period output
- NOM_PERIOD, 100, nominal clk_in period in clk cycles
- TOL, 2, allowed absolute deviation from NOM_PERIOD, in cycles
- LOCK_CNT, 4, consecutive in-tolerance periods required to assert lock
- TIMEOUT, 1000, clk cycles without a clk_in rising edge before the clock is declared lost

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  reset, asynchronous, active-high
- en  input  1  monitor enable, synchronous to clk
- clk_in  input  1  monitored clock, asynchronous to clk
- period  output  CNT_W  last measured period, in clk cycles
- period_vld  output  1  one-cycle pulse when period updates
- in_range  output  1  last period within NOM_PERIOD ± TOL
- lock  output  1  LOCK_CNT consecutive in-range periods seen
- timeout  output  1  clk_in lost; high while in LOST

Behaviour:
- Reset: all outputs 0; counters 0; state IDLE; synchronizer flops 0.
- Input path: clk_in goes through a 2-flop synchronizer, then a third flop for edge detection. edge = sync & ~prev. The edge pulse occurs 3 clk cycles after clk_in is first sampled high.
- Counter cnt (CNT_W bits, saturating at all-ones):
  - On an edge cycle: cnt <= 0.
  - Otherwise: cnt <= cnt + 1.
- States:
  - IDLE: cnt held at 0. en=1 moves to WAIT_FIRST.
  - WAIT_FIRST: counting. An edge moves to MEASURE with no period output; this is the reference edge. cnt+1 == TIMEOUT moves to LOST.
  - MEASURE, on an edge:
    - period <= cnt + 1 and period_vld = 1 for 1 cycle.
    - in_range <= (|cnt+1 − NOM_PERIOD| <= TOL).
    - If in range: good_cnt increments, saturating at LOCK_CNT. lock = 1 once good_cnt == LOCK_CNT.
    - If out of range: good_cnt <= 0 and lock <= 0 in the same cycle period_vld is asserted.
  - MEASURE, no edge with cnt+1 == TIMEOUT: go to LOST.
  - LOST:
    - On entry: timeout = 1, lock = 0, good_cnt = 0. period and in_range keep their last values.
    - A first edge goes to MEASURE and clears timeout. That edge is the new reference; no period_vld.
- en=0 in any state: next cycle go to IDLE. lock, timeout and good_cnt are cleared; period and in_range are retained.
- Edge and timeout on the same cycle: the edge wins. The period is reported normally (period = TIMEOUT) and LOST is not entered.
- Arithmetic: in-range compare done at CNT_W+1 bits signed to avoid wrap. period saturates at 2^CNT_W−1.
- Reset asserted mid-operation: immediate return to reset values, no partial pulse. After release, IDLE.
- Steady 1 MHz input, en held: period_vld every 100 cycles, period = 100.

Optional Feature:
- Macro CLK_MON_MINMAX_EN.
- Defined: adds outputs period_min and period_max (CNT_W each) and input minmax_clr (1).
  - Reset/clear value: min = all-ones, max = 0.
  - Updated on every period_vld.
  - minmax_clr has priority over a same-cycle update.
  - en=0 does not clear them.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, en=1, clk_in 1 MHz (50 cycles high / 50 low) -> first edge gives no pulse; then period_vld every 100 cycles with period=100, in_range=1; lock rises on the 4th period_vld.
- Locked, then one clk_in period of 90 cycles -> period=90, in_range=0, lock=0 on that pulse. Then 100-cycle periods -> lock re-asserts after 4 more pulses.
- Locked, clk_in held low -> timeout=1 and lock=0 exactly 1000 cycles after the last edge. clk_in restarts -> first edge clears timeout with no pulse; next edge gives period=100.
- clk_in period of exactly 1000 cycles -> period=1000 reported with period_vld; timeout stays 0.
- en dropped mid-measurement, then raised -> lock=0 next cycle, period retained. After en=1, the first edge gives no pulse and lock needs 4 new periods.
- rst_n pulsed high for 3 cycles while locked -> all outputs 0 during reset. Measurement restarts from IDLE after release (en=1: first edge gives no pulse).
